// File: rtl/asteroid_pkg.sv
// asteroid_pkg: shared spawn FSM states, screen geometry and LFSR taps for asteroid game logic
package asteroid_pkg;
   typedef enum logic [1:0] {IDLE, WAIT, PICK, ISSUE} spawn_state_t;
   localparam logic [9:0] SCREEN_W = 10'd640;
   localparam logic [9:0] SCREEN_H = 10'd480;
   localparam logic [9:0] FRAME_ROW = 10'd480;
   // Fibonacci taps 16,14,13,11 as bit positions 15,13,12,10
   localparam logic [15:0] LFSR_TAPS = 16'hB400;
endpackage

// File: rtl/lfsr16.sv
// lfsr16: 16-bit Fibonacci LFSR, shifts left and feeds the tap parity into bit 0
module lfsr16
   import asteroid_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic [15:0] seed,
   output logic [15:0] q
);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) q <= seed;
      else if (en) q <= {q[14:0], ^(q & LFSR_TAPS)};
endmodule

// File: rtl/asteroid_spawner.sv
// asteroid_spawner: per-frame move pulse, difficulty ramp and LFSR-placed respawns into free slots
module asteroid_spawner
   import asteroid_pkg::*;
#(
   parameter int          NUM_AST      = 4,
   parameter int          SPAWN_GAP    = 60,
   parameter int          X_MIN        = 20,
   parameter int          X_MAX        = 619,
   parameter logic [15:0] LFSR_SEED    = 16'hACE1,
   parameter int          LEVEL_FRAMES = 600,
   parameter int          MAX_LEVEL    = 5
)(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               pixpulse,
   input  logic [9:0]         hcount,
   input  logic [9:0]         vcount,
   input  logic               enable,
   input  logic [NUM_AST-1:0] broken,
   output logic               move,
   output logic [NUM_AST-1:0] unbreak,
   output logic [9:0]         spawn_x,
   output logic [2:0]         level,
   output logic               frame_tick
);
   localparam int SW = NUM_AST > 1 ? $clog2(NUM_AST) : 1;
   spawn_state_t state, state_nx;
   logic [15:0] lfsr, gap, gap_nx, lvl_cnt, lvl_cnt_nx, reload;
   logic [SW-1:0] slot, slot_nx, free_idx;
   logic [9:0] spawn_x_nx, cand;
   logic [2:0] level_nx;
   logic [1:0] to_cnt, to_cnt_nx;
   logic frame, unused;
   lfsr16 u_lfsr (.clk(clk), .rst_n(rst_n), .en(pixpulse), .seed(LFSR_SEED), .q(lfsr));
   assign frame = pixpulse && hcount == 10'd0 && vcount == FRAME_ROW;
   assign cand = lfsr[9:0];
   assign unused = ^lfsr[15:10];
   assign unbreak = state == ISSUE ? NUM_AST'(1) << slot : '0;
   // reload sees the level that takes effect on this same pixpulse
   assign reload = (SPAWN_GAP >> level_nx) == 0 ? 16'd1 : 16'(SPAWN_GAP >> level_nx);
   always_comb begin
      free_idx = '0;
      for (int i = NUM_AST - 1; i >= 0; i--) if (broken[i]) free_idx = SW'(i);
   end
   always_comb begin
      lvl_cnt_nx = lvl_cnt;
      level_nx = level;
      if (frame && enable) begin
         lvl_cnt_nx = lvl_cnt == 16'(LEVEL_FRAMES - 1) ? '0 : lvl_cnt + 16'd1;
         level_nx = lvl_cnt == 16'(LEVEL_FRAMES - 1) && level < 3'(MAX_LEVEL) ? level + 3'd1 : level;
      end
   end
   always_comb begin
      state_nx = state;
      gap_nx = gap;
      slot_nx = slot;
      spawn_x_nx = spawn_x;
      to_cnt_nx = to_cnt;
      if (pixpulse) begin
         if (!enable) state_nx = IDLE;
         else case (state)
            IDLE: begin
               gap_nx = reload;
               state_nx = WAIT;
            end
            WAIT:
               if (gap == '0 && |broken) begin
                  slot_nx = free_idx;
                  state_nx = PICK;
               end else if (frame && gap != '0) gap_nx = gap - 16'd1;
            // out-of-range candidates are retried on the next LFSR value
            PICK:
               if (cand <= 10'(X_MAX - X_MIN)) begin
                  spawn_x_nx = 10'(X_MIN) + cand;
                  to_cnt_nx = '0;
                  state_nx = ISSUE;
               end
            ISSUE:
               if (!broken[slot] || to_cnt == 2'd3) begin
                  gap_nx = reload;
                  state_nx = WAIT;
               end else to_cnt_nx = to_cnt + 2'd1;
            default: state_nx = IDLE;
         endcase
      end
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= IDLE;
         gap <= '0;
         slot <= '0;
         spawn_x <= 10'(X_MIN);
         to_cnt <= '0;
         lvl_cnt <= '0;
         level <= '0;
         move <= 1'b0;
         frame_tick <= 1'b0;
      end else begin
         state <= state_nx;
         gap <= gap_nx;
         slot <= slot_nx;
         spawn_x <= spawn_x_nx;
         to_cnt <= to_cnt_nx;
         lvl_cnt <= lvl_cnt_nx;
         level <= level_nx;
         if (pixpulse) begin
            frame_tick <= frame;
            move <= frame && enable;
         end
      end
endmodule

// File: tb/tb_asteroid_spawner.sv
// tb_asteroid_spawner: randomized frames/pixpulses/broken flags checked against a spec-level model
module tb_asteroid_spawner;
   localparam int N = 4, GAP = 20, XMIN = 20, XMAX = 619, LF = 10, ML = 5;
   localparam int P_IDLE = 0, P_WAIT = 1, P_PICK = 2, P_ISSUE = 3;
   logic clk = 0, rst_n = 0, pixpulse = 0, enable = 0;
   logic [9:0] hcount = 0, vcount = 0;
   logic [N-1:0] broken = '0, unbreak, exp_ub = '0;
   logic move, frame_tick, prev_move = 0, prev_tick = 0;
   logic [9:0] spawn_x;
   logic [2:0] level;
   int checks = 0, failures = 0;
   int m_phase, m_gap, m_slot, m_x, m_level, m_lcnt, m_lfsr, m_issued, m_move, m_tick;
   int pp_since = 0, frames = 0, moves = 0, fticks = 0, bmode = 0, rand_en = 0, n, pps;
   always #5 clk = ~clk;
   asteroid_spawner #(.NUM_AST(N), .SPAWN_GAP(GAP), .X_MIN(XMIN), .X_MAX(XMAX),
      .LEVEL_FRAMES(LF), .MAX_LEVEL(ML)) dut (
      .clk(clk), .rst_n(rst_n), .pixpulse(pixpulse), .hcount(hcount), .vcount(vcount),
      .enable(enable), .broken(broken), .move(move), .unbreak(unbreak), .spawn_x(spawn_x),
      .level(level), .frame_tick(frame_tick));
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
      end
   endtask
   function automatic int lowest(input logic [N-1:0] b);
      for (int i = 0; i < N; i++) if (b[i]) return i;
      return 0;
   endfunction
   task automatic m_reset;
      m_phase = P_IDLE; m_gap = 0; m_slot = 0; m_x = XMIN; m_level = 0; m_lcnt = 0;
      m_lfsr = 16'hACE1; m_issued = 0; m_move = 0; m_tick = 0;
   endtask
   task automatic m_step;
      int fr, cand, nb, rl;
      if (!rst_n) begin m_reset(); return; end
      if (!pixpulse) return;
      fr = int'(hcount == 0 && vcount == 480);
      cand = m_lfsr % 1024;
      nb = ((m_lfsr >> 15) ^ (m_lfsr >> 13) ^ (m_lfsr >> 12) ^ (m_lfsr >> 10)) & 1;
      m_lfsr = ((m_lfsr << 1) | nb) & 32'hFFFF;
      m_tick = fr;
      m_move = fr & int'(enable);
      if (fr == 1 && enable) begin
         m_lcnt++;
         if (m_lcnt == LF) begin m_lcnt = 0; if (m_level < ML) m_level++; end
      end
      rl = GAP >> m_level;
      if (rl < 1) rl = 1;
      if (!enable) m_phase = P_IDLE;
      else if (m_phase == P_IDLE) begin m_gap = rl; m_phase = P_WAIT; end
      else if (m_phase == P_WAIT) begin
         if (m_gap == 0 && broken != 0) begin m_slot = lowest(broken); m_phase = P_PICK; end
         else if (fr == 1 && m_gap > 0) m_gap--;
      end else if (m_phase == P_PICK) begin
         if (cand <= XMAX - XMIN) begin m_x = XMIN + cand; m_issued = 0; m_phase = P_ISSUE; end
      end else begin
         m_issued++;
         if (!broken[m_slot] || m_issued == 4) begin m_gap = rl; m_phase = P_WAIT; end
      end
   endtask
   task automatic drive;
      pixpulse = $urandom_range(0, 3) != 0;
      if (pixpulse && pp_since >= 5) begin
         hcount = 0; vcount = 480; pp_since = 0;
      end else if (!pixpulse && $urandom_range(0, 3) == 0) begin
         hcount = 0; vcount = 480;
      end else begin
         hcount = 10'($urandom_range(1, 639)); vcount = 10'($urandom_range(0, 524));
         if (pixpulse) pp_since++;
      end
      if (rand_en != 0 && $urandom_range(0, 299) == 0) enable = !enable;
      if (bmode == 1) begin
         if (exp_ub != 0 && $urandom_range(0, 1) == 1) broken = broken & ~exp_ub;
         if ($urandom_range(0, 15) == 0) broken[$urandom_range(0, N - 1)] = 1'b1;
      end
   endtask
   task automatic cycle;
      @(negedge clk);
      drive();
      @(posedge clk);
      m_step();
      if (pixpulse && hcount == 0 && vcount == 480) frames++;
      #1;
      exp_ub = m_phase == P_ISSUE ? N'(1) << m_slot : '0;
      check("move", move, m_move);
      check("frame_tick", frame_tick, m_tick);
      check("unbreak", unbreak, exp_ub);
      check("spawn_x", spawn_x, m_x);
      check("level", level, m_level);
      check("unbreak_onehot", $countones(unbreak) <= 1, 1);
      check("spawn_x_range", spawn_x >= 10'(XMIN) && spawn_x <= 10'(XMAX), 1);
      if (move && !prev_move) moves++;
      if (frame_tick && !prev_tick) fticks++;
      prev_move = move;
      prev_tick = frame_tick;
   endtask
   task automatic run_frames(input int k);
      frames = 0; n = 0;
      while (frames < k && n < 2000) begin cycle(); n++; end
      check("frames_reached", frames, k);
   endtask
   task automatic run_to_issue(input string tag);
      n = 0;
      while (m_phase != P_ISSUE && n < 4000) begin cycle(); n++; end
      check(tag, unbreak != 0, 1);
   endtask
   initial begin
      #5_000_000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end
   initial begin
      m_reset();
      repeat (3) cycle();
      check("rst_unbreak", unbreak, 0);
      check("rst_spawn_x", spawn_x, XMIN);
      check("rst_level", level, 0);
      check("rst_move", move, 0);
      rst_n = 1;
      fticks = 0; moves = 0;
      run_frames(3);
      check("paused_ticks", fticks, 3);
      check("paused_moves", moves, 0);
      enable = 1; broken = 4'b1010; moves = 0;
      run_frames(3);
      check("run_moves", moves, 3);
      run_to_issue("issue_timeout_reached");
      check("slot_lowest", unbreak, 4'b0010);
      pps = 0; n = 0;
      while (unbreak != 0 && n < 100) begin cycle(); if (pixpulse) pps++; n++; end
      check("timeout_pixpulses", pps, 4);
      run_to_issue("issue_ack_reached");
      check("slot_again", unbreak, 4'b0010);
      broken = 4'b1000;
      n = 0;
      do begin cycle(); n++; end while (!pixpulse && n < 100);
      check("ack_clears", unbreak, 0);
      broken = 4'b0000;
      n = 0;
      while (!(m_phase == P_WAIT && m_gap == 0) && n < 4000) begin cycle(); n++; end
      repeat (20) cycle();
      check("nofree_idle", unbreak, 0);
      broken = 4'b1000; pps = 0; n = 0;
      while (unbreak == 0 && n < 200) begin cycle(); if (pixpulse) pps++; n++; end
      check("nofree_spawn", unbreak, 4'b1000);
      check("spawn_latency_min", pps >= 2, 1);
      bmode = 1; rand_en = 1;
      repeat (2500) cycle();
      rand_en = 0; enable = 1;
      run_to_issue("issue_before_reset");
      rst_n = 0;
      #2;
      m_reset();
      check("async_unbreak", unbreak, 0);
      check("async_level", level, 0);
      check("async_spawn_x", spawn_x, XMIN);
      check("async_move", move, 0);
      repeat (2) cycle();
      rst_n = 1;
      enable = 0;
      repeat (10) cycle();
      check("idle_after_reset", unbreak, 0);
      enable = 1;
      run_frames(75);
      check("level_saturated", level, ML);
      repeat (300) cycle();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
